// File: rtl/probe_ack_responder.sv
// Client-side responder for TileLink channel-B probes: downgrades the directory line to the probe cap and answers on channel C.
// Optional perf counters are built when PROBE_RESP_PERF_EN is defined; otherwise both perf ports read 0.
module probe_ack_responder (
  input  logic         clock,
  input  logic         reset,
  input  logic         io_probe_valid,
  output logic         io_probe_ready,
  input  logic [1:0]   io_probe_bits_param,
  input  logic [5:0]   io_probe_bits_source,
  input  logic [9:0]   io_probe_bits_set,
  input  logic [19:0]  io_probe_bits_tag,
  output logic         io_dirReq_valid,
  output logic [9:0]   io_dirReq_set,
  output logic [19:0]  io_dirReq_tag,
  input  logic         io_dirResp_hit,
  input  logic [2:0]   io_dirResp_way,
  input  logic [1:0]   io_dirResp_state,
  input  logic         io_dirResp_dirty,
  output logic         io_dirWrite_valid,
  output logic [9:0]   io_dirWrite_set,
  output logic [2:0]   io_dirWrite_way,
  output logic [1:0]   io_dirWrite_state,
  output logic         io_dirWrite_dirty,
  output logic         io_dataReq_valid,
  output logic [9:0]   io_dataReq_set,
  output logic [2:0]   io_dataReq_way,
  output logic         io_dataReq_beat,
  input  logic [255:0] io_dataResp_data,
  output logic         io_c_valid,
  input  logic         io_c_ready,
  output logic [2:0]   io_c_bits_opcode,
  output logic [2:0]   io_c_bits_param,
  output logic [5:0]   io_c_bits_source,
  output logic [9:0]   io_c_bits_set,
  output logic [19:0]  io_c_bits_tag,
  output logic [255:0] io_c_bits_data,
  output logic         io_c_bits_beat,
  output logic         io_busy,
  output logic [31:0]  io_perf_probes,
  output logic [31:0]  io_perf_dataAcks
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_RESP    = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_SEND    = 3'd5;
  localparam logic [2:0] ST_UPDATE  = 3'd6;

  localparam logic [1:0] DIR_INVALID = 2'd0;
  localparam logic [1:0] DIR_BRANCH  = 2'd1;

  localparam logic [1:0] CAP_TOT = 2'd0;
  localparam logic [1:0] CAP_TOB = 2'd1;

  localparam logic [2:0] OP_PROBE_ACK      = 3'd4;
  localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;

  // Report param for a lookup result; cap 3 falls into the toN default.
  function automatic logic [2:0] report_param(input logic hit, input logic [1:0] state,
                                              input logic [1:0] cap);
    logic [2:0] p;
    if (!hit || state == DIR_INVALID) begin
      p = 3'd5;
    end else if (state == DIR_BRANCH) begin
      p = (cap == CAP_TOT || cap == CAP_TOB) ? 3'd4 : 3'd2;
    end else begin
      case (cap)
        CAP_TOT: p = 3'd3;
        CAP_TOB: p = 3'd0;
        default: p = 3'd1;
      endcase
    end
    return p;
  endfunction

  // Directory state after applying the cap to a valid line.
  function automatic logic [1:0] capped_state(input logic [1:0] state, input logic [1:0] cap);
    logic [1:0] s;
    case (cap)
      CAP_TOT: s = state;
      CAP_TOB: s = DIR_BRANCH;
      default: s = DIR_INVALID;
    endcase
    return s;
  endfunction

  logic [2:0]   state_r;
  logic         probe_ready_r;
  logic         busy_r;
  logic         dir_req_valid_r;
  logic         data_req_valid_r;
  logic         dir_write_valid_r;
  logic         c_valid_r;
  logic [1:0]   cap_r;
  logic [5:0]   source_r;
  logic [9:0]   set_r;
  logic [19:0]  tag_r;
  logic [2:0]   way_r;
  logic [2:0]   opcode_r;
  logic [2:0]   param_r;
  logic [1:0]   new_state_r;
  logic         write_pend_r;
  logic         need_data_r;
  logic         beat_r;
  logic [255:0] data_r;

  logic         probe_fire_s;
  logic         c_fire_s;
  logic         lookup_valid_s;
  logic [1:0]   resp_new_state_s;

  assign probe_fire_s     = io_probe_valid & probe_ready_r;
  assign c_fire_s         = c_valid_r & io_c_ready;
  assign lookup_valid_s   = io_dirResp_hit & (io_dirResp_state != DIR_INVALID);
  assign resp_new_state_s = lookup_valid_s ? capped_state(io_dirResp_state, cap_r) : DIR_INVALID;

  // Transaction FSM; every strobe and C field is a register updated on entry to its state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      probe_ready_r     <= 1'b1;
      busy_r            <= 1'b0;
      dir_req_valid_r   <= 1'b0;
      data_req_valid_r  <= 1'b0;
      dir_write_valid_r <= 1'b0;
      c_valid_r         <= 1'b0;
      cap_r             <= 2'd0;
      source_r          <= 6'd0;
      set_r             <= 10'd0;
      tag_r             <= 20'd0;
      way_r             <= 3'd0;
      opcode_r          <= 3'd0;
      param_r           <= 3'd0;
      new_state_r       <= 2'd0;
      write_pend_r      <= 1'b0;
      need_data_r       <= 1'b0;
      beat_r            <= 1'b0;
      data_r            <= 256'd0;
    end else begin
      dir_req_valid_r   <= 1'b0;
      data_req_valid_r  <= 1'b0;
      dir_write_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (probe_fire_s) begin
            cap_r           <= io_probe_bits_param;
            source_r        <= io_probe_bits_source;
            set_r           <= io_probe_bits_set;
            tag_r           <= io_probe_bits_tag;
            beat_r          <= 1'b0;
            data_r          <= 256'd0;
            probe_ready_r   <= 1'b0;
            busy_r          <= 1'b1;
            dir_req_valid_r <= 1'b1;
            state_r         <= ST_LOOKUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          way_r        <= io_dirResp_way;
          param_r      <= report_param(io_dirResp_hit, io_dirResp_state, cap_r);
          new_state_r  <= resp_new_state_s;
          write_pend_r <= lookup_valid_s &
                          ((resp_new_state_s != io_dirResp_state) | io_dirResp_dirty);
          need_data_r  <= io_dirResp_hit & io_dirResp_dirty;
          if (io_dirResp_hit & io_dirResp_dirty) begin
            opcode_r         <= OP_PROBE_ACK_DATA;
            data_req_valid_r <= 1'b1;
            state_r          <= ST_READ;
          end else begin
            opcode_r  <= OP_PROBE_ACK;
            c_valid_r <= 1'b1;
            state_r   <= ST_SEND;
          end
        end
        ST_READ: begin
          state_r <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          data_r    <= io_dataResp_data;
          c_valid_r <= 1'b1;
          state_r   <= ST_SEND;
        end
        ST_SEND: begin
          if (c_fire_s) begin
            c_valid_r <= 1'b0;
            if (need_data_r && !beat_r) begin
              beat_r           <= 1'b1;
              data_req_valid_r <= 1'b1;
              state_r          <= ST_READ;
            end else begin
              dir_write_valid_r <= write_pend_r;
              state_r           <= ST_UPDATE;
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        ST_UPDATE: begin
          probe_ready_r <= 1'b1;
          busy_r        <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          c_valid_r     <= 1'b0;
          probe_ready_r <= 1'b1;
          busy_r        <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PROBE_RESP_PERF_EN
  logic [31:0] perf_probes_r;
  logic [31:0] perf_data_acks_r;

  // Probe and data-ack counters, wrapping modulo 2^32.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_probes_r    <= 32'd0;
      perf_data_acks_r <= 32'd0;
    end else begin
      if (probe_fire_s) begin
        perf_probes_r <= perf_probes_r + 32'd1;
      end else begin
        perf_probes_r <= perf_probes_r;
      end
      if (c_fire_s && beat_r) begin
        perf_data_acks_r <= perf_data_acks_r + 32'd1;
      end else begin
        perf_data_acks_r <= perf_data_acks_r;
      end
    end
  end

  assign io_perf_probes   = perf_probes_r;
  assign io_perf_dataAcks = perf_data_acks_r;
`else
  assign io_perf_probes   = 32'd0;
  assign io_perf_dataAcks = 32'd0;
`endif

  assign io_probe_ready    = probe_ready_r;
  assign io_busy           = busy_r;
  assign io_dirReq_valid   = dir_req_valid_r;
  assign io_dirReq_set     = set_r;
  assign io_dirReq_tag     = tag_r;
  assign io_dirWrite_valid = dir_write_valid_r;
  assign io_dirWrite_set   = set_r;
  assign io_dirWrite_way   = way_r;
  assign io_dirWrite_state = new_state_r;
  assign io_dirWrite_dirty = 1'b0;
  assign io_dataReq_valid  = data_req_valid_r;
  assign io_dataReq_set    = set_r;
  assign io_dataReq_way    = way_r;
  assign io_dataReq_beat   = beat_r;
  assign io_c_valid        = c_valid_r;
  assign io_c_bits_opcode  = opcode_r;
  assign io_c_bits_param   = param_r;
  assign io_c_bits_source  = source_r;
  assign io_c_bits_set     = set_r;
  assign io_c_bits_tag     = tag_r;
  assign io_c_bits_data    = data_r;
  assign io_c_bits_beat    = beat_r;

endmodule

// File: tb/tb_probe_ack_responder.sv
// Self-checking bench for probe_ack_responder: table-driven report model, per-cycle C/directory checks, directed probes.
`timescale 1ns/1ps
module tb_probe_ack_responder;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         io_probe_valid = 1'b0;
  logic         io_probe_ready;
  logic [1:0]   io_probe_bits_param = 2'd0;
  logic [5:0]   io_probe_bits_source = 6'd0;
  logic [9:0]   io_probe_bits_set = 10'd0;
  logic [19:0]  io_probe_bits_tag = 20'd0;
  logic         io_dirReq_valid;
  logic [9:0]   io_dirReq_set;
  logic [19:0]  io_dirReq_tag;
  logic         io_dirResp_hit = 1'b0;
  logic [2:0]   io_dirResp_way = 3'd0;
  logic [1:0]   io_dirResp_state = 2'd0;
  logic         io_dirResp_dirty = 1'b0;
  logic         io_dirWrite_valid;
  logic [9:0]   io_dirWrite_set;
  logic [2:0]   io_dirWrite_way;
  logic [1:0]   io_dirWrite_state;
  logic         io_dirWrite_dirty;
  logic         io_dataReq_valid;
  logic [9:0]   io_dataReq_set;
  logic [2:0]   io_dataReq_way;
  logic         io_dataReq_beat;
  logic [255:0] io_dataResp_data = 256'd0;
  logic         io_c_valid;
  logic         io_c_ready = 1'b1;
  logic [2:0]   io_c_bits_opcode;
  logic [2:0]   io_c_bits_param;
  logic [5:0]   io_c_bits_source;
  logic [9:0]   io_c_bits_set;
  logic [19:0]  io_c_bits_tag;
  logic [255:0] io_c_bits_data;
  logic         io_c_bits_beat;
  logic         io_busy;
  logic [31:0]  io_perf_probes;
  logic [31:0]  io_perf_dataAcks;

  probe_ack_responder dut (
    .clock(clock), .reset(reset),
    .io_probe_valid(io_probe_valid), .io_probe_ready(io_probe_ready),
    .io_probe_bits_param(io_probe_bits_param), .io_probe_bits_source(io_probe_bits_source),
    .io_probe_bits_set(io_probe_bits_set), .io_probe_bits_tag(io_probe_bits_tag),
    .io_dirReq_valid(io_dirReq_valid), .io_dirReq_set(io_dirReq_set), .io_dirReq_tag(io_dirReq_tag),
    .io_dirResp_hit(io_dirResp_hit), .io_dirResp_way(io_dirResp_way),
    .io_dirResp_state(io_dirResp_state), .io_dirResp_dirty(io_dirResp_dirty),
    .io_dirWrite_valid(io_dirWrite_valid), .io_dirWrite_set(io_dirWrite_set),
    .io_dirWrite_way(io_dirWrite_way), .io_dirWrite_state(io_dirWrite_state),
    .io_dirWrite_dirty(io_dirWrite_dirty),
    .io_dataReq_valid(io_dataReq_valid), .io_dataReq_set(io_dataReq_set),
    .io_dataReq_way(io_dataReq_way), .io_dataReq_beat(io_dataReq_beat),
    .io_dataResp_data(io_dataResp_data),
    .io_c_valid(io_c_valid), .io_c_ready(io_c_ready),
    .io_c_bits_opcode(io_c_bits_opcode), .io_c_bits_param(io_c_bits_param),
    .io_c_bits_source(io_c_bits_source), .io_c_bits_set(io_c_bits_set),
    .io_c_bits_tag(io_c_bits_tag), .io_c_bits_data(io_c_bits_data),
    .io_c_bits_beat(io_c_bits_beat), .io_busy(io_busy),
    .io_perf_probes(io_perf_probes), .io_perf_dataAcks(io_perf_dataAcks)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Report model: explicit table over (directory state, cap normalised so 3 means toN).
  function automatic logic [1:0] norm_cap(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  function automatic logic [2:0] mdl_param(input logic hit, input logic [1:0] st, input logic [1:0] cap);
    if (!hit) return 3'd5;
    case ({st, norm_cap(cap)})
      4'b01_00: return 3'd4;
      4'b01_01: return 3'd4;
      4'b01_10: return 3'd2;
      4'b10_00: return 3'd3;
      4'b10_01: return 3'd0;
      4'b10_10: return 3'd1;
      4'b11_00: return 3'd3;
      4'b11_01: return 3'd0;
      4'b11_10: return 3'd1;
      default:  return 3'd5;
    endcase
  endfunction

  function automatic logic [1:0] mdl_new(input logic [1:0] st, input logic [1:0] cap);
    case ({st, norm_cap(cap)})
      4'b01_00: return 2'd1;
      4'b01_01: return 2'd1;
      4'b10_00: return 2'd2;
      4'b10_01: return 2'd1;
      4'b11_00: return 2'd3;
      4'b11_01: return 2'd1;
      default:  return 2'd0;
    endcase
  endfunction

  logic [5:0]   exp_src;
  logic [9:0]   exp_set;
  logic [19:0]  exp_tag;
  logic [2:0]   exp_way;
  logic [2:0]   exp_param;
  logic [1:0]   exp_new;
  logic         exp_need;
  logic         exp_write;
  logic [255:0] exp_data [2];
  logic         tb_hit;
  logic [1:0]   tb_st;
  logic         tb_dirty;
  logic         checking = 1'b1;
  int           mdl_probes = 0;
  int           mdl_dacks = 0;

  logic [255:0] junk_data = {8{32'hDEADBEEF}};

  task automatic set_exp(input logic [1:0] cap, input logic [5:0] src, input logic [9:0] set,
                         input logic [19:0] tag, input logic hit, input logic [2:0] way,
                         input logic [1:0] st, input logic dirty);
    exp_src   = src;
    exp_set   = set;
    exp_tag   = tag;
    exp_way   = way;
    exp_param = mdl_param(hit, st, cap);
    exp_new   = mdl_new(st, cap);
    exp_need  = hit && dirty;
    exp_write = hit && (st != 2'd0) && ((exp_new != st) || dirty);
    exp_data[0] = {8{{12'hB00, tag} ^ 32'h0F0F0F0F}};
    exp_data[1] = {8{{12'hB11, tag} ^ 32'h3C3C3C3C}};
    tb_hit   = hit;
    tb_st    = st;
    tb_dirty = dirty;
    mdl_probes++;
    if (exp_need) mdl_dacks++;
    io_probe_bits_param  = cap;
    io_probe_bits_source = src;
    io_probe_bits_set    = set;
    io_probe_bits_tag    = tag;
  endtask

  // Directory and data arrays answer exactly one cycle after their request strobe, junk otherwise.
  logic         dp_hit = 1'b1;
  logic [2:0]   dp_way = 3'd5;
  logic [1:0]   dp_st = 2'd2;
  logic         dp_dirty = 1'b1;
  logic [255:0] dat_pend = 256'd0;
  always @(negedge clock) begin
    io_dirResp_hit   = dp_hit;
    io_dirResp_way   = dp_way;
    io_dirResp_state = dp_st;
    io_dirResp_dirty = dp_dirty;
    if (io_dirReq_valid) begin
      dp_hit = tb_hit; dp_way = exp_way; dp_st = tb_st; dp_dirty = tb_dirty;
    end else begin
      dp_hit = 1'b1; dp_way = 3'd5; dp_st = 2'd2; dp_dirty = 1'b1;
    end
    io_dataResp_data = dat_pend;
    dat_pend = io_dataReq_valid ? exp_data[io_dataReq_beat] : junk_data;
  end

  // Per-cycle compare of all meaningful outputs against the model.
  logic         prev_hold = 1'b0;
  logic [42:0]  snap_hdr;
  logic [255:0] snap_data;
  always @(negedge clock) begin
    if (!reset || !checking) begin
      prev_hold = 1'b0;
    end else begin
      if (io_c_valid) begin
        chk("c_opcode", io_c_bits_opcode, exp_need ? 3'd5 : 3'd4);
        chk("c_param", io_c_bits_param, exp_param);
        chk("c_source", io_c_bits_source, exp_src);
        chk("c_set", io_c_bits_set, exp_set);
        chk("c_tag", io_c_bits_tag, exp_tag);
        chk("c_data", io_c_bits_data, exp_need ? exp_data[io_c_bits_beat] : 256'd0);
        if (!exp_need) chk("c_beat_single", io_c_bits_beat, 1'b0);
        if (prev_hold) begin
          chk("c_hdr_stable", {io_c_bits_opcode, io_c_bits_param, io_c_bits_source, io_c_bits_set,
                               io_c_bits_tag, io_c_bits_beat}, snap_hdr);
          chk("c_data_stable", io_c_bits_data, snap_data);
        end
      end else if (prev_hold) begin
        chk("c_valid_dropped", io_c_valid, 1'b1);
      end
      if (io_dirReq_valid) begin
        chk("dirreq_set", io_dirReq_set, exp_set);
        chk("dirreq_tag", io_dirReq_tag, exp_tag);
      end
      if (io_dataReq_valid) begin
        chk("datareq_set", io_dataReq_set, exp_set);
        chk("datareq_way", io_dataReq_way, exp_way);
      end
      if (io_dirWrite_valid) begin
        chk("dirwrite_wanted", exp_write, 1'b1);
        chk("dirwrite_set", io_dirWrite_set, exp_set);
        chk("dirwrite_way", io_dirWrite_way, exp_way);
        chk("dirwrite_state", io_dirWrite_state, exp_new);
        chk("dirwrite_dirty", io_dirWrite_dirty, 1'b0);
      end
      prev_hold = io_c_valid && !io_c_ready;
      snap_hdr  = {io_c_bits_opcode, io_c_bits_param, io_c_bits_source, io_c_bits_set,
                   io_c_bits_tag, io_c_bits_beat};
      snap_data = io_c_bits_data;
    end
  end

  // One full probe; cycle 0 is the cycle whose closing edge fires the probe.
  task automatic run_probe(input logic [1:0] cap, input logic [5:0] src, input logic [9:0] set,
                           input logic [19:0] tag, input logic hit, input logic [2:0] way,
                           input logic [1:0] st, input logic dirty, input int stall,
                           output int first_valid, output int idle_cyc);
    int cyc, fire0, valid1, nfire, last_fire, dw, dw_cyc, stall_left;
    logic vprev;
    set_exp(cap, src, set, tag, hit, way, st, dirty);
    @(posedge clock); #1;
    chk("probe_ready_before", io_probe_ready, 1'b1);
    io_probe_valid = 1'b1;
    @(posedge clock); #1;
    io_probe_valid = 1'b0;
    cyc = 1; first_valid = -1; valid1 = -1; fire0 = -1; nfire = 0; last_fire = -1;
    dw = 0; dw_cyc = -1; idle_cyc = -1; vprev = 1'b0; stall_left = stall;
    while (idle_cyc < 0 && cyc < 80) begin
      if (io_c_valid && !vprev) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          chk("beat_first", io_c_bits_beat, 1'b0);
        end else begin
          valid1 = cyc;
          chk("beat_second", io_c_bits_beat, 1'b1);
        end
      end
      if (io_dirWrite_valid) begin dw++; dw_cyc = cyc; end
      if (io_probe_ready) begin
        idle_cyc = cyc;
        chk("busy_idle", io_busy, 1'b0);
      end else begin
        chk("busy_active", io_busy, 1'b1);
      end
      if (io_c_valid && stall_left > 0) begin
        io_c_ready = 1'b0;
        stall_left--;
      end else begin
        io_c_ready = 1'b1;
      end
      if (io_c_valid && io_c_ready) begin
        nfire++;
        last_fire = cyc;
        if (fire0 < 0) fire0 = cyc;
      end
      vprev = io_c_valid;
      if (idle_cyc < 0) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    chk("idle_reached", io_probe_ready, 1'b1);
    chk("first_valid_cycle", first_valid, exp_need ? 5 : 3);
    chk("stall_length", fire0 - first_valid, stall);
    chk("c_fire_count", nfire, exp_need ? 2 : 1);
    if (exp_need) chk("beat1_valid_gap", valid1 - fire0, 3);
    chk("dirwrite_count", dw, exp_write ? 1 : 0);
    if (exp_write) chk("dirwrite_cycle", dw_cyc, last_fire + 1);
    chk("idle_after_update", idle_cyc - last_fire, 2);
  endtask

  initial begin
    int fv, ic;
    tb_hit = 1'b0; tb_st = 2'd0; tb_dirty = 1'b0; exp_way = 3'd0;
    exp_data[0] = 256'd0; exp_data[1] = 256'd0;
    exp_need = 1'b0; exp_write = 1'b0;

    // Model pins, hand-derived from the report mapping.
    chk("pin_miss_param", mdl_param(1'b0, 2'd3, 2'd2), 3'd5);
    chk("pin_tip_tob", {mdl_param(1'b1, 2'd3, 2'd1), mdl_new(2'd3, 2'd1)}, {3'd0, 2'd1});
    chk("pin_tip_ton", {mdl_param(1'b1, 2'd3, 2'd2), mdl_new(2'd3, 2'd2)}, {3'd1, 2'd0});
    chk("pin_branch_tot", {mdl_param(1'b1, 2'd1, 2'd0), mdl_new(2'd1, 2'd0)}, {3'd4, 2'd1});
    chk("pin_trunk_cap3", mdl_param(1'b1, 2'd2, 2'd3), 3'd1);

    #12;
    chk("rst_probe_ready", io_probe_ready, 1'b1);
    chk("rst_quiet", {io_busy, io_c_valid, io_dirReq_valid, io_dataReq_valid, io_dirWrite_valid}, 5'd0);
    chk("rst_perf", {io_perf_probes, io_perf_dataAcks}, 64'd0);
    @(negedge clock); reset = 1'b1;
    mdl_probes = 0; mdl_dacks = 0;

    run_probe(2'd2, 6'h11, 10'h3A5, 20'h12345, 1'b0, 3'd0, 2'd0, 1'b0, 0, fv, ic);
    chk("miss_c_at_3", fv, 3);
    chk("miss_idle_at_5", ic, 5);
    run_probe(2'd1, 6'h22, 10'h001, 20'hABCDE, 1'b1, 3'd2, 2'd3, 1'b0, 0, fv, ic);
    run_probe(2'd2, 6'h3F, 10'h3FF, 20'hFFFFF, 1'b1, 3'd6, 2'd3, 1'b1, 0, fv, ic);
    chk("dirty_c_at_5", fv, 5);
    run_probe(2'd0, 6'h05, 10'h155, 20'h0F0F0, 1'b1, 3'd1, 2'd1, 1'b0, 10, fv, ic);
    run_probe(2'd3, 6'h07, 10'h200, 20'h00001, 1'b1, 3'd7, 2'd2, 1'b0, 0, fv, ic);
    run_probe(2'd2, 6'h08, 10'h010, 20'h80000, 1'b1, 3'd3, 2'd1, 1'b0, 2, fv, ic);
    run_probe(2'd0, 6'h09, 10'h0AA, 20'h55555, 1'b1, 3'd4, 2'd2, 1'b1, 3, fv, ic);
    run_probe(2'd0, 6'h0A, 10'h0BB, 20'h00777, 1'b1, 3'd0, 2'd0, 1'b0, 0, fv, ic);
`ifdef PROBE_RESP_PERF_EN
    chk("perf_probes_mid", io_perf_probes, mdl_probes);
    chk("perf_dacks_mid", io_perf_dataAcks, mdl_dacks);
`else
    chk("perf_probes_mid", io_perf_probes, 32'd0);
    chk("perf_dacks_mid", io_perf_dataAcks, 32'd0);
`endif

    // Reset pulse while the dirty line is being captured.
    set_exp(2'd2, 6'h2A, 10'h123, 20'h3C3C3, 1'b1, 3'd6, 2'd3, 1'b1);
    @(posedge clock); #1; io_probe_valid = 1'b1;
    @(posedge clock); #1; io_probe_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    checking = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstmid_probe_ready", io_probe_ready, 1'b1);
    chk("rstmid_quiet", {io_busy, io_c_valid, io_dirReq_valid, io_dataReq_valid, io_dirWrite_valid}, 5'd0);
    chk("rstmid_c_fields", {io_c_bits_opcode, io_c_bits_param, io_c_bits_source, io_c_bits_beat}, 13'd0);
    chk("rstmid_c_data", io_c_bits_data, 256'd0);
    chk("rstmid_dir_fields", {io_dirReq_set, io_dirReq_tag, io_dataReq_way}, 33'd0);
    chk("rstmid_perf", {io_perf_probes, io_perf_dataAcks}, 64'd0);
    mdl_probes = 0; mdl_dacks = 0;
    exp_write = 1'b0;
    @(negedge clock); reset = 1'b1; checking = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      chk("post_rst_idle", {io_probe_ready, io_busy, io_dirWrite_valid, io_c_valid}, 4'b1000);
    end

    run_probe(2'd2, 6'h01, 10'h3A5, 20'h12345, 1'b0, 3'd0, 2'd0, 1'b0, 0, fv, ic);
    run_probe(2'd1, 6'h02, 10'h2F0, 20'hDEAD5, 1'b1, 3'd5, 2'd3, 1'b1, 1, fv, ic);
    run_probe(2'd1, 6'h03, 10'h0C3, 20'h0BEEF, 1'b1, 3'd2, 2'd1, 1'b0, 0, fv, ic);
`ifdef PROBE_RESP_PERF_EN
    chk("perf_probes", io_perf_probes, mdl_probes);
    chk("perf_dacks", io_perf_dataAcks, mdl_dacks);
    chk("perf_probes_lit", io_perf_probes, 32'd3);
    chk("perf_dacks_lit", io_perf_dataAcks, 32'd1);
`else
    chk("perf_probes_off", io_perf_probes, 32'd0);
    chk("perf_dacks_off", io_perf_dataAcks, 32'd0);
`endif

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
